bus_ic: RTL and testbench

Parametrised multi-master, multi-slave system bus interconnect for the pipelined CPU's peripheral space.
- Successor to the single-master, fixed three-slave combinational decoder.
- Adds round-robin arbitration between masters (e.g. ifetch and LSU).
- Adds a req/ack handshake per slave, registered response, and an error response for unmapped addresses or slave timeout.
- Sits between the core's bus masters and the ROM/RAM/UART and future peripherals.

---
 rtl/bus_ic_pkg.sv | 26 ++
 rtl/bus_ic_rr_arbiter.sv | 27 ++
 rtl/bus_ic.sv | 185 ++++++++++++++++++
 tb/tb_bus_ic.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ic_pkg.sv
// Shared constants and types for the peripheral bus interconnect.
// Slot numbering follows the core's memory map: ROM, RAM, UART, then future peripherals.
package bus_ic_pkg;

  localparam int BUS_SEL_W       = 4;
  localparam int SLOT_ROM        = 0;
  localparam int SLOT_RAM        = 1;
  localparam int SLOT_UART       = 2;
  localparam int BUS_TIMEOUT_DEF = 255;
  localparam int CNT_W           = 10;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic        INVALID   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_t;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_ic_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// Requests are rotated so ptr sits at bit 0, the lowest set bit is isolated, then rotated back.
module bus_ic_rr_arbiter
  import bus_ic_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int M_W   = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [M_W-1:0]   ptr,
  output logic [NUM_M-1:0] gnt
);

  logic [2*NUM_M-1:0] req_dbl;
  logic [2*NUM_M-1:0] gnt_dbl;
  logic [NUM_M-1:0]   rot_req;
  logic [NUM_M-1:0]   rot_gnt;

  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot_req = req_dbl[NUM_M-1:0];
    rot_gnt = rot_req & (~rot_req + 1'b1);
    gnt_dbl = {rot_gnt, rot_gnt} << ptr;
    gnt     = gnt_dbl[2*NUM_M-1:NUM_M];
  end

endmodule

// File: rtl/bus_ic.sv
// Multi-master, multi-slave peripheral bus interconnect with round-robin arbitration,
// per-slave req/ack handshake, registered response and error on unmapped address or timeout.
module bus_ic
  import bus_ic_pkg::*;
#(
  parameter int                         NUM_M   = 2,
  parameter int                         NUM_S   = 8,
  parameter int                         ADDR_W  = 32,
  parameter int                         DATA_W  = 32,
  parameter logic [NUM_S*BUS_SEL_W-1:0] S_SEL   = {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h3, 4'h8, 4'h9},
  parameter logic [NUM_S-1:0]           S_EN    = 8'b0000_0111,
  parameter int                         TIMEOUT = BUS_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         m_req_i,
  input  logic [NUM_M-1:0]         m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr_i,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata_i,
  output logic [NUM_M-1:0]         m_gnt_o,
  output logic [NUM_M-1:0]         m_rvalid_o,
  output logic [DATA_W-1:0]        m_rdata_o,
  output logic                     m_err_o,
  output logic [NUM_S-1:0]         s_req_o,
  output logic                     s_we_o,
  output logic [ADDR_W-1:0]        s_addr_o,
  output logic [DATA_W-1:0]        s_wdata_o,
  input  logic [NUM_S-1:0]         s_ack_i,
  input  logic [NUM_S*DATA_W-1:0]  s_rdata_i
);

  localparam int                M_W    = idx_w(NUM_M);
  localparam int                S_W    = idx_w(NUM_S);
  localparam logic [CNT_W-1:0]  TO_LIM = CNT_W'(TIMEOUT);

  bus_state_t          state_reg, state_next;
  logic [M_W-1:0]      ptr_reg, ptr_next;
  logic [M_W-1:0]      owner_reg, owner_next;
  logic [S_W-1:0]      slot_reg, slot_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;

  logic [NUM_M-1:0]     arb_gnt;
  logic [M_W-1:0]       win_idx;
  logic [ADDR_W-1:0]    win_addr;
  logic [BUS_SEL_W-1:0] win_region;
  logic [NUM_S-1:0]     sel_match;
  logic                 dec_hit;
  logic [S_W-1:0]       dec_slot;
  logic                 ack_hit;
  logic [DATA_W-1:0]    slot_rdata;

  bus_ic_rr_arbiter #(
    .NUM_M (NUM_M),
    .M_W   (M_W)
  ) u_arb (
    .req (m_req_i),
    .ptr (ptr_reg),
    .gnt (arb_gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (arb_gnt[i]) win_idx = M_W'(i);
    end
  end

  assign win_addr   = m_addr_i[win_idx*ADDR_W +: ADDR_W];
  assign win_region = win_addr[ADDR_W-1 -: BUS_SEL_W];

  generate
    for (genvar gi = 0; gi < NUM_S; gi++) begin : g_match
      assign sel_match[gi] = S_EN[gi] && (S_SEL[gi*BUS_SEL_W +: BUS_SEL_W] == win_region);
    end
  endgenerate

  // Scan downward so duplicate selectors resolve to the lowest slot.
  always_comb begin
    dec_hit  = INVALID;
    dec_slot = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if (sel_match[i]) begin
        dec_hit  = 1'b1;
        dec_slot = S_W'(i);
      end
    end
  end

  assign ack_hit    = s_ack_i[slot_reg];
  assign slot_rdata = s_rdata_i[slot_reg*DATA_W +: DATA_W];

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    slot_next  = slot_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|m_req_i) begin
          owner_next = win_idx;
          we_next    = m_we_i[win_idx];
          addr_next  = win_addr;
          wdata_next = m_wdata_i[win_idx*DATA_W +: DATA_W];
          slot_next  = dec_slot;
          cnt_next   = '0;
          rdata_next = '0;
          err_next   = !dec_hit;
          state_next = dec_hit ? ST_BUSY : ST_RESP;
        end
      end
      ST_BUSY: begin
        cnt_next = cnt_reg + 1'b1;
        // An ack arriving on the timeout cycle still completes normally.
        if (ack_hit) begin
          rdata_next = we_reg ? '0 : slot_rdata;
          err_next   = 1'b0;
          state_next = ST_RESP;
        end else if (cnt_reg + 1'b1 == TO_LIM) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_next   = (owner_reg == M_W'(NUM_M - 1)) ? '0 : owner_reg + 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      slot_reg  <= '0;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      slot_reg  <= slot_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  assign m_gnt_o   = (state_reg == ST_IDLE && !rst) ? arb_gnt : '0;
  assign m_rdata_o = (state_reg == ST_RESP) ? rdata_reg : '0;
  assign m_err_o   = (state_reg == ST_RESP) && err_reg;
  assign s_we_o    = we_reg;
  assign s_addr_o  = addr_reg;
  assign s_wdata_o = wdata_reg;

  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_rvalid
      assign m_rvalid_o[gi] = (state_reg == ST_RESP) && (owner_reg == M_W'(gi));
    end
    for (genvar gi = 0; gi < NUM_S; gi++) begin : g_sreq
      assign s_req_o[gi] = (state_reg == ST_BUSY) && (slot_reg == S_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_bus_ic.sv
// Scoreboard bench for bus_ic: directed transactions push expected grants, slave
// requests and responses; independent monitors pop and compare as the DUT presents them.
module tb_bus_ic;

  localparam int NM = 2;
  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req_i, m_we_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM*DW-1:0]  m_wdata_i;
  logic [NM-1:0]     m_gnt_o, m_rvalid_o;
  logic [DW-1:0]     m_rdata_o;
  logic              m_err_o;
  logic [NS-1:0]     s_req_o;
  logic              s_we_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_wdata_o;
  logic [NS-1:0]     s_ack_i;
  logic [NS*DW-1:0]  s_rdata_i;

  always #5 clk = ~clk;

  bus_ic #(
    .NUM_M   (NM),
    .NUM_S   (NS),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_req_i    (m_req_i),
    .m_we_i     (m_we_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .m_err_o    (m_err_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_ack_i    (s_ack_i),
    .s_rdata_i  (s_rdata_i)
  );

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [7:0]  mask;
    int          len;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sreq_t;

  resp_t exp_q[$];
  sreq_t sreq_q[$];
  int    gnt_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_gnt_cyc = 0;

  // Slave model controls, written by the main sequence mid-cycle.
  int          ack_wait = 0;
  logic        ack_en   = 1'b0;
  logic [31:0] ack_data = 32'h0;
  logic        inj_late = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    32'(m_gnt_o),    32'h0);
    check({tag, "_rvalid"}, 32'(m_rvalid_o), 32'h0);
    check({tag, "_rdata"},  m_rdata_o,       32'h0);
    check({tag, "_err"},    32'(m_err_o),    32'h0);
    check({tag, "_sreq"},   32'(s_req_o),    32'h0);
    check({tag, "_swe"},    32'(s_we_o),     32'h0);
    check({tag, "_saddr"},  s_addr_o,        32'h0);
    check({tag, "_swdata"}, s_wdata_o,       32'h0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave responder: acks the selected slot after ack_wait BUSY cycles.
  initial begin
    int busy_n;
    busy_n    = 0;
    s_ack_i   = '0;
    s_rdata_i = '0;
    forever begin
      @(negedge clk);
      s_ack_i = '0;
      for (int i = 0; i < NS; i++) s_rdata_i[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
      if (inj_late) begin
        s_ack_i[0]        = 1'b1;
        s_rdata_i[0 +: DW] = 32'hBAD0_BAD0;
        inj_late          = 1'b0;
        busy_n            = 0;
      end else if (s_req_o != '0) begin
        if (ack_en && busy_n == ack_wait) begin
          s_ack_i = s_req_o;
          for (int i = 0; i < NS; i++) if (s_req_o[i]) s_rdata_i[i*DW +: DW] = ack_data;
        end
        busy_n++;
      end else begin
        busy_n = 0;
      end
    end
  end

  // Grant monitor.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (m_gnt_o != '0) begin
        if (gnt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_gnt: got %b expected none", m_gnt_o);
        end else begin
          e = gnt_q.pop_front();
          check("gnt_onehot", 32'(m_gnt_o), 32'(1 << e));
          last_gnt_cyc = cyc;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (m_rvalid_o != '0) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rvalid: got %b expected none", m_rvalid_o);
        end else begin
          r = exp_q.pop_front();
          check("rvalid_owner", 32'(m_rvalid_o), 32'(1 << r.m));
          check("rdata", m_rdata_o, r.rdata);
          check("err", 32'(m_err_o), 32'(r.err));
          check("latency", 32'(cyc - last_gnt_cyc), 32'(r.lat));
          $display("resp m%0d rdata=%h err=%0d lat=%0d", r.m, m_rdata_o, m_err_o, cyc - last_gnt_cyc);
        end
      end else if (m_rdata_o !== '0 || m_err_o !== 1'b0) begin
        total++; bad++;
        $display("FAIL idle_resp_bus: got rdata=%h err=%b expected 0", m_rdata_o, m_err_o);
      end
    end
  end

  // Slave-request monitor: checks target slot, latched fields and request length.
  initial begin
    int         run;
    logic [7:0] mask;
    sreq_t      s;
    run  = 0;
    mask = '0;
    forever begin
      @(negedge clk);
      if (s_req_o != '0) begin
        if (run == 0) begin
          mask = s_req_o;
          if (sreq_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_sreq: got %b expected none", s_req_o);
          end else begin
            s = sreq_q[0];
            check("sreq_slot", 32'(s_req_o), 32'(s.mask));
            check("s_we", 32'(s_we_o), 32'(s.we));
            check("s_addr", s_addr_o, s.addr);
            check("s_wdata", s_wdata_o, s.wdata);
          end
        end else if (s_req_o !== mask) begin
          total++; bad++;
          $display("FAIL sreq_stable: got %b expected %b", s_req_o, mask);
        end
        run++;
      end else if (run > 0) begin
        if (sreq_q.size() > 0) begin
          s = sreq_q.pop_front();
          check("sreq_len", 32'(run), 32'(s.len));
        end
        run = 0;
      end
    end
  end

  task automatic issue(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bit ok = 1'b0;
    m_we_i[m]              = we;
    m_addr_i[m*AW +: AW]   = addr;
    m_wdata_i[m*DW +: DW]  = wd;
    m_req_i[m]             = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (m_gnt_o[m]) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      total++; bad++;
      $display("FAIL gnt_timeout m%0d: got no grant expected grant", m);
    end
    m_req_i[m] = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || sreq_q.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0 || sreq_q.size() != 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size() + sreq_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    m_req_i   = '0;
    m_we_i    = '0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Both masters together, two rounds: grant order 0,1,0,1.
    ack_en = 1'b1; ack_wait = 0; ack_data = 32'h1111_2222;
    for (int rnd = 0; rnd < 2; rnd++) begin
      gnt_q.push_back(0);
      gnt_q.push_back(1);
      exp_q.push_back('{0, 32'h1111_2222, 1'b0, 2});
      exp_q.push_back('{1, 32'h1111_2222, 1'b0, 2});
      sreq_q.push_back('{8'b0000_0010, 1, 1'b0, 32'h8000_0004, 32'h0});
      sreq_q.push_back('{8'b0000_0010, 1, 1'b0, 32'h8000_0008, 32'h0});
      fork
        issue(0, 1'b0, 32'h8000_0004, 32'h0);
        issue(1, 1'b0, 32'h8000_0008, 32'h0);
      join
      wait_done();
    end

    // M0 zero-wait RAM read.
    ack_data = 32'hDEAD_BEEF;
    gnt_q.push_back(0);
    exp_q.push_back('{0, 32'hDEAD_BEEF, 1'b0, 2});
    sreq_q.push_back('{8'b0000_0010, 1, 1'b0, 32'h8000_0010, 32'h0});
    issue(0, 1'b0, 32'h8000_0010, 32'h0);
    wait_done();

    // M1 UART write with 3 wait states; slave drives junk read data that must be dropped.
    ack_wait = 3; ack_data = 32'hFFFF_FFFF;
    gnt_q.push_back(1);
    exp_q.push_back('{1, 32'h0, 1'b0, 5});
    sreq_q.push_back('{8'b0000_0100, 4, 1'b1, 32'h3000_0000, 32'h41});
    issue(1, 1'b1, 32'h3000_0000, 32'h41);
    wait_done();

    // M0 unmapped read.
    ack_wait = 0;
    gnt_q.push_back(0);
    exp_q.push_back('{0, 32'h0, 1'b1, 1});
    issue(0, 1'b0, 32'h5000_0000, 32'h1234);
    wait_done();

    // ROM never acks: timeout after 4 BUSY cycles, then a late ack in RESP.
    ack_en = 1'b0;
    gnt_q.push_back(0);
    exp_q.push_back('{0, 32'h0, 1'b1, 5});
    sreq_q.push_back('{8'b0000_0001, 4, 1'b0, 32'h9000_0000, 32'h0});
    issue(0, 1'b0, 32'h9000_0000, 32'h0);
    repeat (4) @(negedge clk);
    #1;
    inj_late = 1'b1;
    wait_done();

    // Reset in the second BUSY cycle drops the transaction.
    gnt_q.push_back(1);
    sreq_q.push_back('{8'b0000_0010, 2, 1'b0, 32'h8000_0020, 32'h0});
    issue(1, 1'b0, 32'h8000_0020, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fresh requests after reset: pointer is back at M0.
    ack_en = 1'b1; ack_wait = 0; ack_data = 32'hC0DE_0001;
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    exp_q.push_back('{0, 32'hC0DE_0001, 1'b0, 2});
    exp_q.push_back('{1, 32'hC0DE_0001, 1'b0, 2});
    sreq_q.push_back('{8'b0000_0001, 1, 1'b0, 32'h9000_0100, 32'h0});
    sreq_q.push_back('{8'b0000_0001, 1, 1'b0, 32'h9000_0200, 32'h0});
    fork
      issue(0, 1'b0, 32'h9000_0100, 32'h0);
      issue(1, 1'b0, 32'h9000_0200, 32'h0);
    join
    wait_done();

    if (gnt_q.size() != 0) begin
      total++; bad++;
      $display("FAIL gnt_pending: got %0d expected 0", gnt_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
